fpadd_sequencer: RTL and testbench
==================================

Name: fpadd_sequencer

Overview:
- Sequences the team's pipelined FP adder through a table of NUM operand pairs held in a small ROM.
- Per entry: fetches the pair, issues one add, waits the adder's fixed latency, then captures and holds the sum for DWELL cycles so the LED / seven-segment stage can show it.
- Sits between the operand ROM, the FP adder and the display logic inside the FP adder system top level.

Parameters:
- NUM, 10: number of operand pairs in the ROM (>=1).
- ADDR_W, 4: ROM address / index width; requires 2^ADDR_W >= NUM.
- LATENCY, 3: adder latency in cycles from the add_valid cycle to a valid add_result (>=1).
- DWELL, 50000000: cycles each result is held with result_valid high (>=1).

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  begin a run; sampled only in IDLE or DONE
- rom_addr  out  ADDR_W  operand ROM address (= index)
- rom_data  in  64  {a[63:32], b[31:0]}; async read, valid in the same cycle as rom_addr
- add_a  out  32  adder operand A, registered
- add_b  out  32  adder operand B, registered
- add_valid  out  1  one-cycle issue strobe to the adder
- add_result  in  32  adder sum; no valid flag, timing set by LATENCY
- result  out  32  last captured sum, held until the next capture
- result_valid  out  1  high during SHOW
- index  out  ADDR_W  current entry number, for LEDs
- busy  out  1  high in FETCH / ISSUE / WAIT / SHOW
- done  out  1  high in DONE

Behaviour:
- Reset: on a clk edge with rst=1, all outputs go to 0, state goes to IDLE, and the counters and index clear. Reset mid-run discards any in-flight adder result; add_result is ignored outside WAIT.
- All outputs are registered.
- States: IDLE, FETCH, ISSUE, WAIT, SHOW, DONE.
- IDLE: start=1 -> FETCH, index=0.
- FETCH (1 cycle): rom_addr=index. At the end of the cycle, add_a<=rom_data[63:32], add_b<=rom_data[31:0], add_valid<=1 -> ISSUE.
- ISSUE (1 cycle): add_valid=1. At the end, add_valid<=0, lat_cnt<=LATENCY-1 -> WAIT.
- WAIT (LATENCY cycles): lat_cnt decrements. At the end of the cycle with lat_cnt==0, result<=add_result and result_valid<=1 -> SHOW. add_result is sampled at the end of the LATENCY-th cycle after the add_valid cycle.
- SHOW (DWELL cycles): dwell_cnt counts DWELL-1 down to 0. At the end:
  - result_valid<=0.
  - If index==NUM-1 -> DONE.
  - Otherwise index<=index+1 -> FETCH.
- Per-entry period is exactly 2+LATENCY+DWELL cycles; there is no overlap between entries.
- DONE: done=1; result holds the last sum; index holds NUM-1. start=1 -> index<=0, done<=0 -> FETCH.
- start while busy is ignored and has no side effects.
- Counter widths are sized by $clog2 of LATENCY and DWELL. The index never exceeds NUM-1.
- add_a / add_b hold their values after ISSUE until the next FETCH.

Optional Feature:
- Macro FPADD_SEQ_LOOP_EN.
- Defined: at the end of the SHOW for entry NUM-1, index<=0 and the state goes to FETCH (wrap-around). done pulses high for exactly that one transition cycle, i.e. the first FETCH cycle of the new pass. DONE is never entered.
- Undefined: behaviour as above, stopping in DONE.

Test Plan:
- Reset values: hold rst for 2 cycles, release -> all outputs 0, busy=0, done=0; no add_valid for 20 cycles without start.
- Basic run: NUM=4, LATENCY=3, DWELL=5; ROM[0]={3F800000,40000000}; bench adder model adds with 3-cycle delay; start pulsed in cycle 0.
  - Required: FETCH in cycle 1; add_valid=1 only in cycle 2 with add_a=3F800000, add_b=40000000.
  - Required: result=40400000 with result_valid=1 in cycles 6-10; index=1 in cycle 11.
- Completion: same setup -> 4 add_valid pulses at cycles 2, 12, 22, 32; done=1 from cycle 41 onward, busy=0, result = sum of ROM[3], index=3.
- start ignored: pulse start in cycles 5 and 15 -> identical waveform to the basic run; restart from DONE with start -> index=0, FETCH the next cycle, done=0.
- Reset mid-run: assert rst in cycle 4 (inside WAIT) -> IDLE next edge, result stays 0, and a late add_result from the model is never captured.
- FPADD_SEQ_LOOP_EN defined, NUM=2, LATENCY=1, DWELL=2 -> period 5; after SHOW of entry 1, FETCH with index=0 at cycle 11; done high only in cycle 11; DONE never reached.

Source files
------------

// File: rtl/fpadd_sequencer_if.sv
// Operand-ROM and FP-adder bus of fpadd_sequencer.
// master = sequencer side, slave = ROM/adder side.
interface fpadd_sequencer_if #(
    parameter int ADDR_W = 4
);
    logic [ADDR_W-1:0] rom_addr;
    logic [63:0]       rom_data;
    logic [31:0]       add_a;
    logic [31:0]       add_b;
    logic              add_valid;
    logic [31:0]       add_result;

    modport master (
        output rom_addr, add_a, add_b, add_valid,
        input  rom_data, add_result
    );

    modport slave (
        input  rom_addr, add_a, add_b, add_valid,
        output rom_data, add_result
    );
endinterface

// File: rtl/fpadd_sequencer.sv
// Steps the pipelined FP adder through NUM ROM operand pairs, holding each sum DWELL cycles.
// Optional FPADD_SEQ_LOOP_EN: wrap to entry 0 after the last entry instead of stopping in DONE.
module fpadd_sequencer #(
    parameter int NUM     = 10,
    parameter int ADDR_W  = 4,
    parameter int LATENCY = 3,
    parameter int DWELL   = 50000000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    fpadd_sequencer_if.master    bus,
    output logic [31:0]          result,
    output logic                 result_valid,
    output logic [ADDR_W-1:0]    index,
    output logic                 busy,
    output logic                 done
);

    localparam int LAT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam int DWL_W = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM - 1);
    localparam logic [LAT_W-1:0]  LAT_LOAD = LAT_W'(LATENCY - 1);
    localparam logic [DWL_W-1:0]  DWL_LOAD = DWL_W'(DWELL - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_ISSUE,
        S_WAIT,
        S_SHOW,
        S_DONE
    } state_t;

    state_t           state;
    logic [LAT_W-1:0] lat_cnt;
    logic [DWL_W-1:0] dwell_cnt;

    // The ROM is addressed straight from the index register, so rom_addr is registered too.
    assign bus.rom_addr = index;

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            index         <= '0;
            lat_cnt       <= '0;
            dwell_cnt     <= '0;
            bus.add_a     <= '0;
            bus.add_b     <= '0;
            bus.add_valid <= 1'b0;
            result        <= '0;
            result_valid  <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register updates from pre-edge values.
            case (state)
                S_IDLE: begin
                    if (start) begin
                        index <= '0;
                        busy  <= 1'b1;
                        state <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    bus.add_a     <= bus.rom_data[63:32];
                    bus.add_b     <= bus.rom_data[31:0];
                    bus.add_valid <= 1'b1;
                    done          <= 1'b0;
                    state         <= S_ISSUE;
                end
                S_ISSUE: begin
                    bus.add_valid <= 1'b0;
                    lat_cnt       <= LAT_LOAD;
                    state         <= S_WAIT;
                end
                S_WAIT: begin
                    // add_result is only trusted on the last WAIT cycle.
                    if (lat_cnt == '0) begin
                        result       <= bus.add_result;
                        result_valid <= 1'b1;
                        dwell_cnt    <= DWL_LOAD;
                        state        <= S_SHOW;
                    end else begin
                        lat_cnt <= lat_cnt - 1'b1;
                    end
                end
                S_SHOW: begin
                    if (dwell_cnt == '0) begin
                        result_valid <= 1'b0;
                        if (index == LAST_IDX) begin
`ifdef FPADD_SEQ_LOOP_EN
                            index <= '0;
                            done  <= 1'b1;
                            state <= S_FETCH;
`else
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= S_DONE;
`endif
                        end else begin
                            index <= index + 1'b1;
                            state <= S_FETCH;
                        end
                    end else begin
                        dwell_cnt <= dwell_cnt - 1'b1;
                    end
                end
                S_DONE: begin
                    if (start) begin
                        index <= '0;
                        done  <= 1'b0;
                        busy  <= 1'b1;
                        state <= S_FETCH;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fpadd_sequencer.sv
// Bench for fpadd_sequencer: ROM table, delayed FP adder model, scoreboard of sums and a cycle-exact waveform model.
// Build with FPADD_SEQ_LOOP_EN defined to exercise the wrap-around variant.
module tb_fpadd_sequencer;

`ifdef FPADD_SEQ_LOOP_EN
    localparam int NUM     = 2;
    localparam int LATENCY = 1;
    localparam int DWELL   = 2;
`else
    localparam int NUM     = 4;
    localparam int LATENCY = 3;
    localparam int DWELL   = 5;
`endif
    localparam int ADDR_W = 4;
    localparam int PERIOD = 2 + LATENCY + DWELL;

    logic              clk;
    logic              rst;
    logic              start;
    logic [31:0]       result;
    logic              result_valid;
    logic [ADDR_W-1:0] index;
    logic              busy;
    logic              done;

    fpadd_sequencer_if #(.ADDR_W(ADDR_W)) bus ();

    fpadd_sequencer #(
        .NUM(NUM), .ADDR_W(ADDR_W), .LATENCY(LATENCY), .DWELL(DWELL)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .bus(bus),
        .result(result), .result_valid(result_valid), .index(index),
        .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] rom_word(input int i);
        case (i)
            0:       return {32'h3F80_0000, 32'h4000_0000};  // 1.0 + 2.0
            1:       return {32'h4040_0000, 32'h4080_0000};  // 3.0 + 4.0
            2:       return {32'h3F00_0000, 32'h3E80_0000};  // 0.5 + 0.25
            3:       return {32'h4120_0000, 32'hC0A0_0000};  // 10.0 + -5.0
            default: return 64'h0;
        endcase
    endfunction

    // Single-precision via double; exact for the normal operands in the table.
    function automatic real sp2r(input logic [31:0] x);
        logic [10:0] e;
        if (x[30:23] == 8'd0) return 0.0;
        e = {3'b000, x[30:23]} + 11'd896;
        return $bitstoreal({x[31], e, x[22:0], 29'd0});
    endfunction

    function automatic logic [31:0] r2sp(input real r);
        logic [63:0] d;
        logic [10:0] e;
        if (r == 0.0) return 32'h0;
        d = $realtobits(r);
        e = d[62:52] - 11'd896;
        return {d[63], e[7:0], d[51:29]};
    endfunction

    function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
        return r2sp(sp2r(a) + sp2r(b));
    endfunction

    assign bus.rom_data = rom_word(int'(bus.rom_addr));

    // Adder model: sum is only presented in its LATENCY slot, garbage otherwise.
    logic [31:0] s_pipe [LATENCY];
    logic        v_pipe [LATENCY];
    always @(posedge clk) begin
        s_pipe[0] <= fp_add(bus.add_a, bus.add_b);
        v_pipe[0] <= bus.add_valid;
        for (int i = 1; i < LATENCY; i++) begin
            s_pipe[i] <= s_pipe[i-1];
            v_pipe[i] <= v_pipe[i-1];
        end
    end
    assign bus.add_result = v_pipe[LATENCY-1] ? s_pipe[LATENCY-1] : 32'hDEAD_BEEF;

    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          sp_a = -1;
    int          sp_b = -1;
    int          issue_n = 0;
    bit          sig_en = 0;
    bit          rv_prev = 0;
    logic [31:0] exp_q [$];
    int          issue_cyc [$];

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Expected {busy, done, add_valid, result_valid, index} for cycle c after the start cycle.
    function automatic logic [ADDR_W+3:0] exp_sig(input int c);
        int e = (c - 1) / PERIOD;
        int ph = (c - 1) % PERIOD;
        int idx;
        logic b, d;
`ifdef FPADD_SEQ_LOOP_EN
        b   = 1'b1;
        d   = (c > 1) && (ph == 0) && (e % NUM == 0);
        idx = e % NUM;
`else
        if (e >= NUM) begin
            idx = NUM - 1;
            return {1'b0, 1'b1, 1'b0, 1'b0, idx[ADDR_W-1:0]};
        end
        b   = 1'b1;
        d   = 1'b0;
        idx = e;
`endif
        return {b, d, (ph == 1), (ph >= LATENCY + 2), idx[ADDR_W-1:0]};
    endfunction

    task automatic push_sums(input int n);
        logic [63:0] w;
        for (int i = 0; i < n; i++) begin
            w = rom_word(i % NUM);
            exp_q.push_back(fp_add(w[63:32], w[31:0]));
        end
    endtask

    task automatic step();
        logic [31:0] e;
        @(posedge clk);
        #1;
        cyc++;
        start = (cyc == sp_a) || (cyc == sp_b);
        if (sig_en)
            chk($sformatf("sig_c%0d", cyc), {busy, done, bus.add_valid, result_valid, index}, exp_sig(cyc));
        if (bus.add_valid) begin
            chk("issue_ops", {bus.add_a, bus.add_b}, rom_word(issue_n % NUM));
            issue_cyc.push_back(cyc);
            issue_n++;
        end
        if (result_valid && !rv_prev) begin
            chk("sb_nonempty", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("sb_result", result, e);
            end
        end
        rv_prev = result_valid;
    endtask

    task automatic begin_run(input int a, input int b, input int n);
        issue_n = 0;
        issue_cyc.delete();
        exp_q.delete();
        push_sums(n);
        sp_a   = a;
        sp_b   = b;
        cyc    = 0;
        start  = 1'b1;
        sig_en = 1'b1;
    endtask

`ifndef FPADD_SEQ_LOOP_EN
    task automatic check_done_and_issues();
        int exp_cyc [4] = '{2, 12, 22, 32};
        chk("done_state", {done, busy, result_valid, index}, {1'b1, 1'b0, 1'b0, 4'd3});
        chk("done_result", result, 32'h40A0_0000);
        chk("issue_count", issue_n, 4);
        for (int i = 0; i < 4; i++)
            chk($sformatf("issue_cyc%0d", i), (i < issue_cyc.size()) ? issue_cyc[i] : -1, exp_cyc[i]);
        chk("sb_drained", exp_q.size(), 0);
    endtask
`endif

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("reset_result", {result_valid, result}, 33'd0);
        chk("reset_ctrl", {busy, done, bus.add_valid, index, bus.rom_addr}, 11'd0);
        chk("reset_ops", {bus.add_a, bus.add_b}, 64'd0);
        repeat (20) step();
        chk("idle_no_issue", issue_n, 0);
        chk("idle_ctrl", {busy, done, result_valid}, 3'd0);

`ifdef FPADD_SEQ_LOOP_EN
        begin_run(-1, -1, 3 * NUM);
        repeat (11) step();
        chk("loop_wrap", {done, busy, index, bus.rom_addr}, {1'b1, 1'b1, 4'd0, 4'd0});
        step();
        chk("loop_done_pulse", done, 1'b0);
        repeat (13) step();
        chk("loop_never_done", {done, busy}, 2'b01);
        chk("loop_issue_count", issue_n, 5);
`else
        // Basic run
        begin_run(-1, -1, NUM);
        step();
        chk("fetch_c1", {busy, bus.add_valid, bus.rom_addr}, {1'b1, 1'b0, 4'd0});
        step();
        chk("issue_c2", {bus.add_valid, bus.add_a, bus.add_b}, {1'b1, 32'h3F80_0000, 32'h4000_0000});
        repeat (4) step();
        chk("result_c6", {result_valid, result}, {1'b1, 32'h4040_0000});
        repeat (5) step();
        chk("index_c11", {result_valid, index}, {1'b0, 4'd1});
        repeat (34) step();
        check_done_and_issues();

        // Restart from DONE with start pulses while busy
        begin_run(5, 15, NUM);
        step();
        chk("restart_fetch", {index, done, busy, bus.rom_addr}, {4'd0, 1'b0, 1'b1, 4'd0});
        repeat (44) step();
        check_done_and_issues();

        // Reset inside WAIT; the adder's late sum must not be captured
        begin_run(-1, -1, NUM);
        repeat (4) step();
        sig_en = 1'b0;
        rst    = 1'b1;
        step();
        rst = 1'b0;
        exp_q.delete();
        chk("midrst_ctrl", {busy, done, bus.add_valid, result_valid, index}, 8'd0);
        chk("midrst_result", result, 32'd0);
        repeat (10) step();
        chk("midrst_no_capture", {result_valid, result}, 33'd0);
        chk("midrst_idle", {busy, done}, 2'b00);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
